sram_port_arbiter: RTL and testbench

- Shares one dual-port SRAM macro between N_REQ requesters (e.g. per-warp operand/scratch clients). Macro: 1W+1R, byte-masked write, 1-cycle registered-address read.
- Separate round-robin arbitration for the write port and the read port, so one write and one read issue per cycle.
- Routes read data back to the owning requester with an ID tag.
- Guarantees deterministic same-address read/write ordering by deferring the read.

---
 rtl/sram_port_arbiter.sv | 119 +++++++++++
 tb/tb_sram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one 1W+1R byte-masked SRAM macro between N_REQ requesters.
//   Independent round-robin arbitration on the write and read ports lets one
//   write and one read issue per cycle. Read data returns one cycle after the
//   grant, tagged with the owning requester's index.
//
// Ports
//   clock, reset        : sole clock (macro W0_clk/R0_clk); async active-low reset
//   req_valid/ready     : per-requester handshake, transfer on valid & ready
//   req_write           : 1 = write, 0 = read
//   req_addr/wdata/wmask: flattened per-requester payload, requester i at [i*W +: W]
//   resp_valid/id/data  : read response (data is a passthrough of mem_r_data)
//   mem_w_*, mem_r_*    : macro write port and read port
//   conflict_cnt        : saturating count of reads deferred by an address clash
module sram_port_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned MASK_W = DATA_W / 8,
  parameter int unsigned ID_W   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  input  logic [N_REQ*MASK_W-1:0]  req_wmask,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     mem_w_en,
  output logic [ADDR_W-1:0]        mem_w_addr,
  output logic [DATA_W-1:0]        mem_w_data,
  output logic [MASK_W-1:0]        mem_w_mask,
  output logic                     mem_r_en,
  output logic [ADDR_W-1:0]        mem_r_addr,
  input  logic [DATA_W-1:0]        mem_r_data,
  output logic [15:0]              conflict_cnt
);

  logic [ID_W-1:0]   wr_ptr, rd_ptr;
  logic [N_REQ-1:0]  wr_cand, rd_cand;
  logic [ID_W:0]     wr_pick, rd_pick;
  logic [ID_W-1:0]   wr_idx, rd_idx;
  logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;
  logic              addr_clash;
  logic              wr_grant, rd_grant, conflict;

  // Returns {found, index}: first candidate at or after ptr, wrapping at N_REQ.
  function automatic logic [ID_W:0] pick(input logic [N_REQ-1:0] cand,
                                         input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   r;
    int unsigned     s;
    logic [ID_W-1:0] i;
    r = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      s = 32'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      i = ID_W'(s);
      if (!r[ID_W] && cand[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    return (32'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  assign wr_cand = req_valid & req_write;
  assign rd_cand = req_valid & ~req_write;
  assign wr_pick = pick(wr_cand, wr_ptr);
  assign rd_pick = pick(rd_cand, rd_ptr);
  assign wr_idx  = wr_pick[ID_W-1:0];
  assign rd_idx  = rd_pick[ID_W-1:0];

  assign wr_addr_sel = req_addr[32'(wr_idx)*ADDR_W +: ADDR_W];
  assign rd_addr_sel = req_addr[32'(rd_idx)*ADDR_W +: ADDR_W];

  // A read that hits the address being written this cycle is held back so it
  // returns post-write data next cycle; the write always proceeds.
  assign addr_clash = wr_pick[ID_W] && rd_pick[ID_W] && (wr_addr_sel == rd_addr_sel);
  assign conflict   = reset && addr_clash;
  assign wr_grant   = reset && wr_pick[ID_W];
  assign rd_grant   = reset && rd_pick[ID_W] && !addr_clash;

  always_comb begin
    mem_w_en   = wr_grant;
    mem_w_addr = wr_grant ? wr_addr_sel : '0;
    mem_w_data = wr_grant ? req_wdata[32'(wr_idx)*DATA_W +: DATA_W] : '0;
    mem_w_mask = wr_grant ? req_wmask[32'(wr_idx)*MASK_W +: MASK_W] : '0;
    mem_r_en   = rd_grant;
    mem_r_addr = rd_grant ? rd_addr_sel : '0;
    req_ready  = (wr_grant ? (N_REQ'(1) << wr_idx) : '0)
               | (rd_grant ? (N_REQ'(1) << rd_idx) : '0);
  end

  assign resp_data = mem_r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (wr_grant) wr_ptr <= next_ptr(wr_idx);
      if (rd_grant) begin
        rd_ptr  <= next_ptr(rd_idx);
        resp_id <= rd_idx;
      end
      resp_valid <= rd_grant;
      if (conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios followed by a randomized
// phase, all checked against a behavioural reference (distance-based
// round-robin pick plus a shadow memory) and a simple SRAM macro model.
module tb_sram_port_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned IW = 2;
  localparam int          NI = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_wmask;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_data;
  logic            mem_w_en, mem_r_en;
  logic [AW-1:0]   mem_w_addr, mem_r_addr;
  logic [DW-1:0]   mem_w_data, mem_r_data;
  logic [MW-1:0]   mem_w_mask;
  logic [15:0]     conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  sram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_mask(mem_w_mask), .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h9E37_79B9};
  endfunction

  // SRAM macro: registered read address, byte-masked write, no reset.
  logic [DW-1:0] sram [0:1023];
  bit            init_done;
  always @(posedge clock) begin
    if (!init_done) begin
      for (int a = 0; a < 1024; a++) sram[a] <= init_word(a);
      init_done <= 1'b1;
    end else begin
      if (mem_r_en) mem_r_data <= sram[mem_r_addr];
      if (mem_w_en)
        for (int b = 0; b < MW; b++)
          if (mem_w_mask[b]) sram[mem_w_addr][b*8 +: 8] <= mem_w_data[b*8 +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:1023];
  int            m_wptr, m_rptr, m_cnt, m_rid;
  bit            m_rv;
  logic [DW-1:0] m_rdata;
  int            w_g, r_g;
  bit            conf;

  function automatic logic [AW-1:0] a_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wmask[i*MW +: MW] = m;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NI; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Winner = candidate with smallest round-robin distance from the pointer.
  task automatic evaluate();
    int bw, br, d;
    bw = NI; br = NI; w_g = -1; r_g = -1; conf = 0;
    if (reset !== 1'b1) return;
    for (int i = 0; i < NI; i++) begin
      if (!req_valid[i]) continue;
      if (req_write[i]) begin
        d = (i - m_wptr + NI) % NI;
        if (d < bw) begin bw = d; w_g = i; end
      end else begin
        d = (i - m_rptr + NI) % NI;
        if (d < br) begin br = d; r_g = i; end
      end
    end
    if (w_g >= 0 && r_g >= 0 && a_of(w_g) == a_of(r_g)) begin
      conf = 1;
      r_g  = -1;
    end
  endtask

  task automatic at_neg();
    logic [N-1:0] exp_ready;
    @(negedge clock);
    evaluate();
    exp_ready = '0;
    if (w_g >= 0) exp_ready[w_g] = 1'b1;
    if (r_g >= 0) exp_ready[r_g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("mem_w_en", 64'(mem_w_en), 64'(w_g >= 0));
    if (w_g >= 0) begin
      chk("mem_w_addr", 64'(mem_w_addr), 64'(a_of(w_g)));
      chk("mem_w_data", mem_w_data, req_wdata[w_g*DW +: DW]);
      chk("mem_w_mask", 64'(mem_w_mask), 64'(req_wmask[w_g*MW +: MW]));
    end
    chk("mem_r_en", 64'(mem_r_en), 64'(r_g >= 0));
    if (r_g >= 0) chk("mem_r_addr", 64'(mem_r_addr), 64'(a_of(r_g)));
    chk("resp_valid", 64'(resp_valid), 64'(m_rv));
    if (m_rv) begin
      chk("resp_id", 64'(resp_id), 64'(m_rid));
      chk("resp_data", resp_data, m_rdata);
    end
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  task automatic at_pos();
    logic [DW-1:0] w;
    @(posedge clock);
    if (reset === 1'b1) begin
      if (r_g >= 0) begin
        m_rv    = 1;
        m_rid   = r_g;
        m_rdata = ref_mem[a_of(r_g)];
        m_rptr  = (r_g + 1) % NI;
      end else m_rv = 0;
      if (w_g >= 0) begin
        w = ref_mem[a_of(w_g)];
        for (int b = 0; b < MW; b++)
          if (req_wmask[w_g*MW + b]) w[b*8 +: 8] = req_wdata[w_g*DW + b*8 +: 8];
        ref_mem[a_of(w_g)] = w;
        m_wptr = (w_g + 1) % NI;
      end
      if (conf && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_cnt = 0; m_rv = 0; m_rid = 0;
  endtask

  function automatic logic [DW-1:0] wd(input int i);
    return 64'hFA00_0000_0000_0000 | 64'(i);
  endfunction

  logic [DW-1:0] dat_a, dat_b;

  initial begin
    dat_a = 64'hAAAA_5555_1234_5678;
    dat_b = 64'hBBBB_CCCC_DEAD_BEEF;
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(a);
    model_reset();
    reset = 1'b1;
    clear_all();
    #2 reset = 1'b0;

    // Reset then idle
    at_neg(); at_pos();
    reset = 1'b1;
    at_neg();
    chk("idle_w_en", 64'(mem_w_en), 64'(0));
    chk("idle_r_en", 64'(mem_r_en), 64'(0));
    chk("idle_resp_valid", 64'(resp_valid), 64'(0));
    chk("idle_cnt", 64'(conflict_cnt), 64'(0));
    at_pos();

    // Write fairness: grants 0,1,2,3,0
    for (int i = 0; i < NI; i++) set_req(i, 1'b1, 1'b1, AW'(i), wd(i), '1);
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("fair_grant", 64'(req_ready), 64'(1) << (k % 4));
      at_pos();
    end
    clear_all();

    // Concurrent ports: req1 writes 5, req2 reads 9
    set_req(1, 1'b1, 1'b1, AW'(5), dat_a, '1);
    set_req(2, 1'b1, 1'b0, AW'(9), '0, '0);
    at_neg();
    chk("conc_ready", 64'(req_ready), 64'h6);
    at_pos();
    clear_all();
    at_neg();
    chk("conc_resp_valid", 64'(resp_valid), 64'(1));
    chk("conc_resp_id", 64'(resp_id), 64'(2));
    chk("conc_resp_data", resp_data, init_word(9));
    at_pos();

    // Conflict: req0 writes 0x3FF (mask 0x0F), req3 reads 0x3FF
    set_req(0, 1'b1, 1'b1, AW'(10'h3FF), dat_b, MW'(8'h0F));
    set_req(3, 1'b1, 1'b0, AW'(10'h3FF), '0, '0);
    at_neg();
    chk("confl_ready", 64'(req_ready), 64'h1);
    at_pos();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    at_neg();
    chk("confl_cnt", 64'(conflict_cnt), 64'(1));
    chk("confl_read_grant", 64'(req_ready), 64'h8);
    at_pos();
    clear_all();
    at_neg();
    chk("confl_resp_id", 64'(resp_id), 64'(3));
    chk("confl_resp_lo", 64'(resp_data[31:0]), 64'(dat_b[31:0]));
    chk("confl_resp_hi", 64'(resp_data[63:32]), 64'(32'hC0DE_03FF));
    at_pos();

    // Read pipeline: req0 reads 1, req1 reads 2
    set_req(0, 1'b1, 1'b0, AW'(1), '0, '0);
    set_req(1, 1'b1, 1'b0, AW'(2), '0, '0);
    at_neg(); at_pos();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    at_neg();
    chk("pipe_id0", 64'(resp_id), 64'(0));
    chk("pipe_data0", resp_data, wd(1));
    at_pos();
    clear_all();
    at_neg();
    chk("pipe_valid1", 64'(resp_valid), 64'(1));
    chk("pipe_id1", 64'(resp_id), 64'(1));
    chk("pipe_data1", resp_data, wd(2));
    at_pos();

    // Reset mid-read
    set_req(2, 1'b1, 1'b0, AW'(5), '0, '0);
    at_neg(); at_pos();
    clear_all();
    chk("mid_resp_valid", 64'(resp_valid), 64'(1));
    chk("mid_resp_data", resp_data, dat_a);
    reset = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    model_reset();
    for (int i = 0; i < NI; i++) set_req(i, 1'b1, 1'b1, AW'(100 + i), wd(i + 8), '1);
    at_neg();
    chk("rst_ready", 64'(req_ready), 64'(0));
    at_pos();
    at_neg(); at_pos();
    reset = 1'b1;
    set_req(0, 1'b1, 1'b1, AW'(100), wd(20), '1);
    set_req(2, 1'b1, 1'b1, AW'(101), wd(21), '1);
    set_req(1, 1'b1, 1'b0, AW'(200), '0, '0);
    set_req(3, 1'b1, 1'b0, AW'(201), '0, '0);
    at_neg();
    chk("post_rst_grant", 64'(req_ready), 64'h3);
    at_pos();
    clear_all();

    // Randomized traffic on a small address window to provoke clashes
    for (int i = 0; i < NI; i++)
      set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 7)), {$urandom, $urandom}, MW'($urandom));
    for (int c = 0; c < 400; c++) begin
      at_neg();
      at_pos();
      for (int i = 0; i < NI; i++)
        if (!req_valid[i] || w_g == i || r_g == i)
          set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), {$urandom, $urandom}, MW'($urandom));
    end
    clear_all();
    at_neg(); at_pos();
    at_neg(); at_pos();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
